// File: rtl/s_axi_read.sv
// rtl/s_axi_read.sv - AXI4-Lite read slave for the DFX sequencer register file.
// Decodes AR into a bank0 register or bank1 slot field and returns the registered value on R.
module s_axi_read #(
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 32,
  parameter int BANK1_INDEX_WIDTH    = 2,
  parameter int BANK1_SRC_ADDR_WIDTH = 32,
  parameter int BANK1_SRC_SIZE_WIDTH = 26,
  parameter int BANK1_DST_ADDR_WIDTH = 32,
  parameter int BANK1_DST_SIZE_WIDTH = 26,
  parameter int BANK1_STATUS_WIDTH   = 2,
  parameter int BANK1_PROFILE_WIDTH  = 32,
  parameter int BANK0_CONTROL_WIDTH  = 4,
  parameter int BANK0_STATUS_WIDTH   = 4,
  parameter int BANK0_CNT_WIDTH      = BANK1_INDEX_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [BANK1_INDEX_WIDTH-1:0]    ext_bank1_out_index,
  input  logic [BANK1_SRC_ADDR_WIDTH-1:0] ext_bank1_out_src_addr,
  input  logic [BANK1_SRC_SIZE_WIDTH-1:0] ext_bank1_out_src_size,
  input  logic [BANK1_DST_ADDR_WIDTH-1:0] ext_bank1_out_des_addr,
  input  logic [BANK1_DST_SIZE_WIDTH-1:0] ext_bank1_out_des_size,
  input  logic [BANK1_STATUS_WIDTH-1:0]   ext_bank1_out_status,
  input  logic [BANK1_PROFILE_WIDTH-1:0]  ext_bank1_out_profile,
  input  logic [BANK0_CONTROL_WIDTH-1:0]  ext_bank0_out_control,
  input  logic [BANK0_STATUS_WIDTH-1:0]   ext_bank0_out_status,
  input  logic [BANK0_CNT_WIDTH-1:0]      ext_bank0_out_cnt,
  input  logic [BANK0_CNT_WIDTH-1:0]      ext_bank0_out_endCnt
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, fetch_data;
  logic [1:0]            rresp_q, rresp_d, fetch_resp;
  logic                  unused_addr_bits;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (S_AXI_ARVALID) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_RESP;
      ST_RESP:  if (S_AXI_RREADY) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (state_q)
      ST_IDLE: S_AXI_ARREADY = 1'b1;
      ST_RESP: S_AXI_RVALID  = 1'b1;
      default: ;
    endcase
  end

  // Bank1 presents the selected row combinationally; the row comes straight from the latched address.
  assign ext_bank1_out_index = read_addr_q[BANK1_INDEX_WIDTH+5:6];
  assign unused_addr_bits    = ^read_addr_q;

  always_comb begin
    fetch_data = '0;
    fetch_resp = RESP_SLVERR;
    case (read_addr_q[15:14])
      2'b00: begin
        fetch_resp = RESP_OKAY;
        case (read_addr_q[13:6])
          8'h00:   fetch_data = DATA_WIDTH'(ext_bank0_out_control);
          8'h01:   fetch_data = DATA_WIDTH'(ext_bank0_out_status);
          8'h02:   fetch_data = DATA_WIDTH'(ext_bank0_out_cnt);
          8'h03:   fetch_data = DATA_WIDTH'(ext_bank0_out_endCnt);
          default: fetch_resp = RESP_SLVERR;
        endcase
      end
      2'b01: begin
        fetch_resp = RESP_OKAY;
        case (read_addr_q[5:2])
          4'd0:    fetch_data = DATA_WIDTH'(ext_bank1_out_src_addr);
          4'd1:    fetch_data = DATA_WIDTH'(ext_bank1_out_src_size);
          4'd2:    fetch_data = DATA_WIDTH'(ext_bank1_out_des_addr);
          4'd3:    fetch_data = DATA_WIDTH'(ext_bank1_out_des_size);
          4'd4:    fetch_data = DATA_WIDTH'(ext_bank1_out_status);
          4'd5:    fetch_data = DATA_WIDTH'(ext_bank1_out_profile);
          default: fetch_resp = RESP_SLVERR;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    read_addr_d = read_addr_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    if (state_q == ST_IDLE && S_AXI_ARVALID) read_addr_d = S_AXI_ARADDR;
    if (state_q == ST_FETCH) begin
      rdata_d = fetch_data;
      rresp_d = fetch_resp;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_addr_q <= '0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
    end else begin
      read_addr_q <= read_addr_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
    end
  end

  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;

endmodule

// File: tb/tb_s_axi_read.sv
// tb/tb_s_axi_read.sv - directed self-checking bench for s_axi_read.
module tb_s_axi_read;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [1:0]  idx;
  logic [31:0] src_addr, des_addr, profile;
  logic [25:0] src_size, des_size;
  logic [1:0]  b1_status;
  logic [3:0]  control, b0_status;
  logic [1:0]  cnt, end_cnt;

  logic [31:0] m_src_addr [4];
  logic [25:0] m_src_size [4];
  logic [31:0] m_des_addr [4];
  logic [25:0] m_des_size [4];
  logic [1:0]  m_status   [4];
  logic [31:0] m_profile  [4];

  int total = 0;
  int bad   = 0;

  assign src_addr  = m_src_addr[idx];
  assign src_size  = m_src_size[idx];
  assign des_addr  = m_des_addr[idx];
  assign des_size  = m_des_size[idx];
  assign b1_status = m_status[idx];
  assign profile   = m_profile[idx];

  always #5 clk = ~clk;

  s_axi_read dut (
    .clk(clk), .reset(rst_n),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ext_bank1_out_index(idx),
    .ext_bank1_out_src_addr(src_addr), .ext_bank1_out_src_size(src_size),
    .ext_bank1_out_des_addr(des_addr), .ext_bank1_out_des_size(des_size),
    .ext_bank1_out_status(b1_status), .ext_bank1_out_profile(profile),
    .ext_bank0_out_control(control), .ext_bank0_out_status(b0_status),
    .ext_bank0_out_cnt(cnt), .ext_bank0_out_endCnt(end_cnt)
  );

  // Complete read with RREADY=1; returns the row index seen in FETCH and edges from handshake to RVALID.
  task automatic do_read(input logic [15:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output logic [1:0] idx_fetch, output int lat);
    int w;
    rready = 1'b1;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    w = 0;
    while (!arready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    idx_fetch = idx;
    lat = 0;
    while (!rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    data = rdata; resp = rresp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    total++; if (arready !== 1'b1) begin bad++; $display("FAIL reset_arready got=%b exp=1", arready); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    total++; if (rdata !== 32'h0 || rresp !== 2'b00) begin bad++; $display("FAIL reset_r got=%h/%b exp=0/00", rdata, rresp); end
    total++; if (idx !== 2'd0) begin bad++; $display("FAIL reset_index got=%0d exp=0", idx); end
  endtask

  task automatic test_bank0_control;
    logic [31:0] d; logic [1:0] r; logic [1:0] ix; int lat;
    control = 4'hA;
    do_read(16'h0000, d, r, ix, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL ctrl_latency got=%0d exp=1 edge after FETCH", lat); end
    total++; if (d !== 32'h0000000A) begin bad++; $display("FAIL ctrl_data got=%h exp=0000000a", d); end
    total++; if (r !== 2'b00) begin bad++; $display("FAIL ctrl_resp got=%b exp=00", r); end
    total++; if (arready !== 1'b1 || rvalid !== 1'b0) begin bad++; $display("FAIL ctrl_idle got=%b%b exp=10", arready, rvalid); end
  endtask

  task automatic test_bank1_fields;
    logic [31:0] d; logic [1:0] r; logic [1:0] ix; int lat;
    do_read(16'h408C, d, r, ix, lat);
    total++; if (ix !== 2'd2) begin bad++; $display("FAIL b1_index got=%0d exp=2", ix); end
    total++; if (d !== 32'h03FFFFFF || r !== 2'b00) begin bad++; $display("FAIL b1_des_size got=%h/%b exp=03ffffff/00", d, r); end
    do_read(16'h4040, d, r, ix, lat);
    total++; if (d !== 32'h11110001 || r !== 2'b00) begin bad++; $display("FAIL b1_src_addr got=%h/%b exp=11110001/00", d, r); end
    do_read(16'h40D0, d, r, ix, lat);
    total++; if (d !== 32'h00000003 || r !== 2'b00) begin bad++; $display("FAIL b1_status got=%h/%b exp=00000003/00", d, r); end
    total++; if (idx !== 2'd3) begin bad++; $display("FAIL b1_index_hold got=%0d exp=3", idx); end
  endtask

  task automatic test_unmapped;
    logic [15:0] addrs [3];
    logic [31:0] d; logic [1:0] r; logic [1:0] ix; int lat;
    addrs[0] = 16'h0100; addrs[1] = 16'h4018; addrs[2] = 16'h8000;
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], d, r, ix, lat);
      total++; if (d !== 32'h0 || r !== 2'b10) begin bad++; $display("FAIL unmapped_%h got=%h/%b exp=0/10", addrs[i], d, r); end
      total++; if (arready !== 1'b1) begin bad++; $display("FAIL unmapped_idle_%h got=%b exp=1", addrs[i], arready); end
    end
  endtask

  task automatic test_backpressure;
    int w;
    rready = 1'b0;
    m_profile[0] = 32'h12345678;
    @(negedge clk); araddr = 16'h4014; arvalid = 1'b1;
    @(posedge clk); #1; arvalid = 1'b0;
    w = 0;
    while (!rvalid && w < 20) begin @(posedge clk); #1; w++; end
    m_profile[0] = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (rvalid !== 1'b1 || rdata !== 32'h12345678 || arready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_%0d got=%b/%h/%b exp=1/12345678/0", i, rvalid, rdata, arready);
      end
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    total++; if (rvalid !== 1'b0 || arready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b%b exp=01", rvalid, arready); end
  endtask

  task automatic test_back_to_back;
    int acc_cyc [2];
    logic [31:0] rd [2];
    int nacc = 0, nresp = 0;
    logic hs_ar, hs_r;
    b0_status = 4'h5; end_cnt = 2'd3;
    rready = 1'b1;
    @(negedge clk); araddr = 16'h0040; arvalid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      if (hs_r && nresp < 2) begin rd[nresp] = rdata; nresp++; end
      @(posedge clk); #1;
      if (hs_ar) begin
        acc_cyc[nacc] = i; nacc++;
        if (nacc == 1) araddr = 16'h00C0; else arvalid = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (nacc !== 2 || nresp !== 2) begin bad++; $display("FAIL b2b_count got=%0d/%0d exp=2/2", nacc, nresp); end
    else begin
      total++; if (acc_cyc[1] - acc_cyc[0] !== 3) begin bad++; $display("FAIL b2b_spacing got=%0d exp=3", acc_cyc[1] - acc_cyc[0]); end
      total++; if (rd[0] !== 32'h5 || rd[1] !== 32'h3) begin bad++; $display("FAIL b2b_data got=%h,%h exp=5,3", rd[0], rd[1]); end
    end
  endtask

  task automatic test_reset_mid_resp;
    logic [31:0] d; logic [1:0] r; logic [1:0] ix; int lat;
    rready = 1'b0;
    @(negedge clk); araddr = 16'h0000; arvalid = 1'b1;
    @(posedge clk); #1; arvalid = 1'b0;
    @(posedge clk); #1;
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL rst_pre_rvalid got=%b exp=1", rvalid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (rvalid !== 1'b0 || arready !== 1'b1) begin bad++; $display("FAIL rst_async got=%b%b exp=01", rvalid, arready); end
    total++; if (rdata !== 32'h0 || idx !== 2'd0) begin bad++; $display("FAIL rst_regs got=%h/%0d exp=0/0", rdata, idx); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_no_resp got=%b exp=0", rvalid); end
    cnt = 2'd2;
    do_read(16'h0080, d, r, ix, lat);
    total++; if (d !== 32'h2 || r !== 2'b00) begin bad++; $display("FAIL rst_fresh_cnt got=%h/%b exp=2/00", d, r); end
  endtask

  initial begin
    rst_n = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    control = 4'h0; b0_status = 4'h0; cnt = 2'd0; end_cnt = 2'd0;
    for (int i = 0; i < 4; i++) begin
      m_src_addr[i] = 32'h11110000 + i;
      m_src_size[i] = 26'h0000100 + 26'(i);
      m_des_addr[i] = 32'h22220000 + i;
      m_des_size[i] = 26'h0000200 + 26'(i);
      m_status[i]   = 2'(i);
      m_profile[i]  = 32'hA0000000 + i;
    end
    m_des_size[2] = 26'h3FFFFFF;
    #12;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    test_bank0_control;
    test_bank1_fields;
    test_unmapped;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_resp;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
